// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// It holds LINES lines of LINE_BITS bits, each with a tag, a valid bit and
// a dirty bit. Load and store hits are serviced with no stall. A miss
// stalls the pipeline while the controller writes back a dirty victim (if
// there is one), fetches the new line, and then spends one settle cycle.
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   cpu_addr_i      byte address: word [4:2], index [8:5], tag [31:9]
//   cpu_data_i      store data
//   cpu_MemRead_i   load request
//   cpu_MemWrite_i  store request (wins if both requests are high)
//   cpu_data_o      load data, zero when no load hits
//   cpu_stall_o     freezes the pipeline registers during a miss
//   mem_addr_o      line-aligned address towards the data memory
//   mem_data_o      victim line during write-back
//   mem_enable_o    memory request, held until mem_ack_i
//   mem_write_o     1 = write-back, 0 = line fill
//   mem_data_i      fill data, valid with mem_ack_i
//   mem_ack_i       single-cycle completion pulse
// ---------------------------------------------------------------------------
module dcache_controller #(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   input  logic                 cpu_MemRead_i,
   input  logic                 cpu_MemWrite_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   localparam int WORDS  = LINE_BITS / 32;
   localparam int WSEL_W = $clog2(WORDS);
   localparam int OFF_W  = $clog2(LINE_BITS / 8);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WRITEBACK  = 2'd1;
   localparam logic [1:0] READMISS   = 2'd2;
   localparam logic [1:0] READMISSOK = 2'd3;

   logic [1:0]           state_reg, state_next;
   logic [LINES-1:0]     valid_reg, dirty_reg;
   logic [TAG_W-1:0]     tag_mem  [LINES];
   logic [LINE_BITS-1:0] data_mem [LINES];

   logic [IDX_W-1:0]     index;
   logic [WSEL_W-1:0]    word_sel;
   logic [TAG_W-1:0]     cpu_tag;
   logic [TAG_W-1:0]     cur_tag;
   logic [LINE_BITS-1:0] cur_line;
   logic [LINE_BITS-1:0] merged_line;
   logic [31:0]          line_words [WORDS];

   logic request, hit, miss, write_hit, fill_done;

   // The byte lanes inside a word are not addressed by this cache.
   logic unused_byte_bits;
   assign unused_byte_bits = ^cpu_addr_i[1:0];

   assign index    = cpu_addr_i[OFF_W +: IDX_W];
   assign word_sel = cpu_addr_i[2 +: WSEL_W];
   assign cpu_tag  = cpu_addr_i[31 -: TAG_W];
   assign cur_tag  = tag_mem[index];
   assign cur_line = data_mem[index];

   // Split the resident line into words for the load mux, and build the
   // line with the addressed word replaced for a store hit.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign line_words[gi] = cur_line[gi*32 +: 32];
         assign merged_line[gi*32 +: 32] =
            (word_sel == WSEL_W'(gi)) ? cpu_data_i : cur_line[gi*32 +: 32];
      end
   endgenerate

   assign request   = cpu_MemRead_i | cpu_MemWrite_i;
   assign hit       = valid_reg[index] & (cur_tag == cpu_tag);
   assign miss      = (state_reg == IDLE) & request & ~hit;
   assign write_hit = (state_reg == IDLE) & cpu_MemWrite_i & hit;
   assign fill_done = (state_reg == READMISS) & mem_ack_i;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (miss) begin
               state_next = (valid_reg[index] & dirty_reg[index]) ? WRITEBACK : READMISS;
            end
         end
         WRITEBACK:  if (mem_ack_i) state_next = READMISS;
         READMISS:   if (mem_ack_i) state_next = READMISSOK;
         READMISSOK: state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         valid_reg <= '0;
         dirty_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (fill_done) begin
            valid_reg[index] <= 1'b1;
            dirty_reg[index] <= 1'b0;
         end else if (write_hit) begin
            dirty_reg[index] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; an ack that lands on a reset edge
   // must not commit a fill.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (fill_done) begin
            data_mem[index] <= mem_data_i;
            tag_mem[index]  <= cpu_tag;
         end else if (write_hit) begin
            data_mem[index] <= merged_line;
         end
      end
   end

   assign cpu_stall_o = miss | (state_reg != IDLE);
   assign cpu_data_o  = (cpu_MemRead_i & ~cpu_MemWrite_i & hit) ? line_words[word_sel] : 32'd0;

   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = 32'd0;
      mem_data_o   = '0;
      case (state_reg)
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {cur_tag, index, {OFF_W{1'b0}}};
            mem_data_o   = cur_line;
         end
         READMISS: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {cpu_tag, index, {OFF_W{1'b0}}};
         end
         default: ;
      endcase
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Consumes the EX/MEM pipeline register outputs (ALU result as address, store data, MemRead/MemWrite) and returns load data to MEM/WB.
- Drives the stall signal that freezes the pipeline registers, including the EX/MEM MemStall input, during a miss.
- Fronts a 256-bit-line off-chip data memory through an enable/ack handshake; holds 16 lines of 32 bytes (512 B) with tag, valid and dirty state.

## Interface

Parameters:
- LINES, 16, number of cache lines (index width = log2(LINES) = 4)
- LINE_BITS, 256, line width in bits (32 bytes, 8 words)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- cpu_addr_i  input  32  byte address; offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits)
- cpu_data_i  input  32  store data
- cpu_MemRead_i  input  1  load request
- cpu_MemWrite_i  input  1  store request
- cpu_data_o  output  32  load data
- cpu_stall_o  output  1  pipeline stall (to MemStall_i of pipeline registers)
- mem_addr_o  output  32  line-aligned memory address, [4:0] = 0
- mem_data_o  output  256  write-back line data
- mem_enable_o  output  1  memory request valid
- mem_write_o  output  1  1 = write-back, 0 = line fill
- mem_data_i  input  256  fill data, valid when mem_ack_i = 1
- mem_ack_i  input  1  single-cycle completion pulse

## Operation

- Request = cpu_MemRead_i | cpu_MemWrite_i. If both are high, treat the request as a store.
- Hit = valid[index] & (tag[index] == cpu_addr_i[31:9]).
- Read hit: cpu_data_o = word [4:2] of the line, combinational. No stall.
- Write hit: replace the selected word at the rising edge and set dirty[index]. No stall.
- Miss (request & !hit in IDLE): cpu_stall_o = 1 combinationally in the same cycle.
- FSM states and transitions:
  - IDLE → WRITEBACK on a miss with valid & dirty victim.
  - IDLE → READMISS on a miss with clean or invalid victim.
  - WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line. On mem_ack_i → READMISS.
  - READMISS: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}. On mem_ack_i: load mem_data_i into the line, set tag, valid = 1, dirty = 0 → READMISSOK.
  - READMISSOK: one cycle with the stall still asserted → IDLE.
- Back in IDLE the request now hits and is serviced as a normal hit (a store sets dirty then).
- cpu_stall_o = (IDLE & request & !hit) | (state != IDLE).
- mem_enable_o is held high in WRITEBACK and READMISS until the ack; it is low in IDLE and READMISSOK.
- The pipeline holds cpu_* inputs stable while stalled; the controller does not latch them.
- A withdrawn request mid-miss still completes the fill.
- When not reading, cpu_data_o = 0.

## Timing

- Reset (synchronous, on rising clk_i with rst_i = 1):
  - state = IDLE; all valid and dirty bits = 0.
  - Tag and data arrays: don't-care.
  - Outputs: cpu_stall_o = 0 (no request), mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_data_o = 0.
- Reset mid-miss:
  - FSM returns to IDLE at that edge; mem_enable_o drops the following cycle.
  - Any fill in flight is discarded; a mem_ack_i arriving after reset is ignored.
- Hit latency: 0 stall cycles.
- Clean miss: stall cycles = 1 (IDLE detect) + N_fill (enable to ack, inclusive) + 1 (READMISSOK).
- Dirty miss: adds N_wb write-back cycles before the fill.
- mem_ack_i outside WRITEBACK or READMISS is ignored.
- An ack arriving in the same cycle the state is entered is legal: advance next edge.
- Back-to-back misses to different indices are serialized; each starts from IDLE.
- Conflict miss on the same index evicts unconditionally; the dirty victim is always written back first.

## Test plan

- Cold read: after reset, load 0x0000_0040 with memory line = {8 words 0x11..0x88} and ack after 3 cycles → stall for 5 cycles, mem_write_o = 0, mem_addr_o = 0x40, then cpu_data_o = 0x11 with stall low.
- Write hit then read: store 0xDEADBEEF to 0x44 after the line is resident → no stall; load 0x44 returns 0xDEADBEEF; dirty[2] = 1.
- Dirty eviction: load 0x0000_0240 (same index 2, tag 1) → WRITEBACK first with mem_addr_o = 0x40, mem_write_o = 1, mem_data_o word1 = 0xDEADBEEF; then fill from 0x240; dirty[2] = 0.
- Clean eviction: repeat the conflict on a clean line → no write-back; only a READMISS request is issued.
- Reset mid-fill: assert rst_i while in READMISS, then ack 1 cycle later → mem_enable_o = 0, ack ignored, next load to the same address misses again.
- Simultaneous read+write asserted on a hit → treated as a store (word updated, dirty set).
